// File: rtl/bus_pkg.sv
// Shared widths and state encoding for the on-chip register bus.
// Responders import the widths from here so both ends stay in agreement.
package bus_pkg;

  localparam int BUS_AW     = 16;
  localparam int BUS_DW     = 16;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } bus_init_state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake plus the register-bus pins of one initiator.
interface bus_initiator_if;
  import bus_pkg::*;

  // req_* and rsp_* are valid/ready pairs: a beat transfers on a rising edge
  // where valid and ready are both 1; the source holds its payload until then.
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [BUS_AW-1:0] req_addr;
  logic [BUS_DW-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [BUS_DW-1:0] rsp_rdata;
  logic [BUS_AW-1:0] baddr;
  logic [BUS_DW-1:0] bwrdata;
  logic [BUS_DW-1:0] brddata;
  logic              bwr;
  logic              bstrobe;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, brddata,
    output req_ready, rsp_valid, rsp_rdata, baddr, bwrdata, bwr, bstrobe
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, brddata,
    input  req_ready, rsp_valid, rsp_rdata, baddr, bwrdata, bwr, bstrobe
  );

endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding register-bus initiator: one strobe per request, read
// data captured RD_LATENCY cycles after the strobe and returned on rsp_*.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int RD_LATENCY = 0  // legal range 0..RD_LAT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  bus_initiator_if.master   bus,
  output logic [BUS_DW-1:0] n_wr,
  output logic [BUS_DW-1:0] n_rd,
  output bus_init_state_t   o_state
);

  bus_init_state_t   r_state;
  logic [BUS_AW-1:0] r_baddr;
  logic [BUS_DW-1:0] r_bwrdata;
  logic [BUS_DW-1:0] r_rsp_rdata;
  logic              r_wr;
  logic              r_bwr;
  logic              r_bstrobe;
  logic              r_rsp_valid;
  logic [LAT_W-1:0]  r_cnt;
  logic [BUS_DW-1:0] r_n_wr;
  logic [BUS_DW-1:0] r_n_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_baddr     <= '0;
      r_bwrdata   <= '0;
      r_rsp_rdata <= '0;
      r_wr        <= 1'b0;
      r_bwr       <= 1'b0;
      r_bstrobe   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
      r_n_wr      <= '0;
      r_n_rd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_baddr   <= bus.req_addr;
            if (bus.req_wr) r_bwrdata <= bus.req_wdata;
            r_wr      <= bus.req_wr;
            r_bwr     <= bus.req_wr;
            r_bstrobe <= 1'b1;
            r_state   <= STROBE;
          end
        end
        STROBE: begin
          r_bstrobe <= 1'b0;
          r_bwr     <= 1'b0;
          if (r_wr) begin
            r_n_wr  <= r_n_wr + 1'b1;
            r_state <= IDLE;
          end else if (RD_LATENCY == 0) begin
            r_rsp_rdata <= bus.brddata;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt   <= LAT_W'(RD_LATENCY);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Counter equals 1 exactly in cycle strobe+RD_LATENCY.
          if (r_cnt == LAT_W'(1)) begin
            r_rsp_rdata <= bus.brddata;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_n_rd      <= r_n_rd + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // req_ready depends on registered state only, never on req_valid.
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.baddr     = r_baddr;
  assign bus.bwrdata   = r_bwrdata;
  assign bus.bwr       = r_bwr;
  assign bus.bstrobe   = r_bstrobe;
  assign n_wr          = r_n_wr;
  assign n_rd          = r_n_rd;
  assign o_state       = r_state;

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Initiator end of the on-chip register bus (`baddr`, `bwrdata`, `brddata`, `bwr`, `bstrobe`) that fabric-side responders decode. It accepts single read/write requests on a valid/ready handshake, issues one strobe cycle per request, and captures read data after a fixed responder latency. Read data is returned on a valid/ready response port. It lets PL logic such as a sequencer or test engine master the bus alongside the PS-side bridge, on the `clk` domain the responders already use.

## Interface
- `RD_LATENCY`, default 0: cycles from strobe cycle to the cycle in which `brddata` is valid; legal range 0..7.
- `clk` in 1: bus clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block accepts a request this cycle.
- `req_wr` in 1: 1 for write, 0 for read.
- `req_addr` in 16: target address.
- `req_wdata` in 16: write data; ignored for reads.
- `rsp_valid` out 1: read data is valid.
- `rsp_ready` in 1: the consumer takes the read data.
- `rsp_rdata` out 16: captured read data.
- `baddr` out 16: bus address.
- `bwrdata` out 16: bus write data.
- `brddata` in 16: bus read data from the responders.
- `bwr` out 1: write qualifier.
- `bstrobe` out 1: one-cycle transaction strobe.
- `n_wr` out 16: count of completed write strobes.
- `n_rd` out 16: count of completed reads, i.e. responses consumed.

## Operation
- States: IDLE, STROBE, WAIT, RESP.
- `req_ready` = (state == IDLE) and is registered-state-derived only; it has no combinational path from `req_valid`.
- IDLE: when `req_valid`, latch `req_addr` into `baddr`, `req_wdata` into `bwrdata` (writes only), and the write flag, then go to STROBE.
- STROBE: `bstrobe` = 1; `bwr` = 1 if write, else 0.
  - Write: increment `n_wr`, go to IDLE.
  - Read with `RD_LATENCY` = 0: capture `brddata` into `rsp_rdata`, go to RESP.
  - Read with `RD_LATENCY` > 0: load the wait counter with `RD_LATENCY`, go to WAIT.
- WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, capture `brddata` and go to RESP.
- RESP: `rsp_valid` = 1 and `rsp_rdata` is held stable. When `rsp_ready`, increment `n_rd` and go to IDLE.
- `bstrobe` and `bwr` are 0 in every state except STROBE.
- `baddr` and `bwrdata` hold their last values until the next accept, so they are stable from strobe through capture.
- Counters wrap from 0xFFFF to 0x0000 with no saturation.
- Only one transaction is ever outstanding; there is no queueing.

## Timing
- Reset values: state IDLE, `req_ready` 1 after reset deasserts, all other outputs 0 (`baddr`, `bwrdata`, `bwr`, `bstrobe`, `rsp_valid`, `rsp_rdata`, `n_wr`, `n_rd`).
- A request accepted at edge N gives `bstrobe` high for exactly cycle N+1.
- Write throughput: one write per 2 cycles under continuous `req_valid`.
- Read with strobe in cycle S:
  - `brddata` is sampled at the end of cycle S+`RD_LATENCY`.
  - `rsp_valid` rises in cycle S+`RD_LATENCY`+1.
  - The earliest next strobe is 2 cycles after the response handshake.
- `rsp_ready` held high: `rsp_valid` lasts exactly 1 cycle.
- `rsp_ready` low: `rsp_valid` and `rsp_rdata` hold indefinitely, and `req_ready` stays 0.
- `reset` in any state returns all outputs to their reset values on the next edge:
  - an in-flight strobe is cut;
  - a pending response is dropped and not counted.
- `req_valid` during non-IDLE states is ignored; the requester must hold it until `req_ready`.

## Structure
- Shared package `bus_pkg`: `BUS_AW` = 16, `BUS_DW` = 16, state enum `bus_init_state_t`; responders reuse the widths from it.
- Single module, no sub-module. The latency counter is 3 bits, sized from the `RD_LATENCY` maximum.

## Test plan
- Write 0x0012 ← 0xBEEF: one `bstrobe` cycle with `bwr`=1, `baddr`=0x0012, `bwrdata`=0xBEEF; `n_wr`=1; `rsp_valid` never asserts.
- Read 0x0034, `RD_LATENCY`=0, responder drives 0xCAFE combinationally: `rsp_rdata`=0xCAFE, `rsp_valid` in cycle S+1, `bwr`=0 throughout.
- `RD_LATENCY`=3, responder presents 0x5A5A only in cycle S+3 and 0xFFFF otherwise: `rsp_rdata`=0x5A5A, `rsp_valid` in cycle S+4.
- Hold `rsp_ready`=0 for 10 cycles with `req_valid` high: `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, no strobes; `n_rd` increments only on the handshake.
- 4 back-to-back writes with `req_valid` held high: strobes in cycles 1, 3, 5, 7; `n_wr`=4. Preload `n_wr`=0xFFFF via 65535 writes (or force), then one write gives 0x0000.
- Assert `reset` during WAIT (`RD_LATENCY`=5): next cycle all outputs are 0, `req_ready`=1, no `rsp_valid`, `n_rd` unchanged.
